plab4_net_router_out_ctrl_tdm: RTL and testbench

This block is a parametrised output-port controller for the secure mesh router. It time-multiplexes the output port between security domains in fixed-length epochs and round-robin arbitrates among same-domain input ports. Multi-flit packets hold their grant from head to tail. It sits between the router input queues and the crossbar, driving the crossbar select and the output valid. Because domain switching depends only on the cycle count, traffic in one domain cannot modulate the output timing seen by another domain.

---
 rtl/plab4_net_pkg.sv | 15 +
 rtl/plab4_net_epoch_ctr.sv | 45 ++++
 rtl/plab4_net_router_out_ctrl_tdm.sv | 102 ++++++++++
 tb/tb_plab4_net_router_out_ctrl_tdm.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/plab4_net_pkg.sv
// Shared widths and types for the secure-mesh router output controllers.
package plab4_net_pkg;

    function automatic int w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int c_num_ports_dflt   = 3;
    localparam int c_num_domains_dflt = 2;
    localparam int c_dom_w = w_of(c_num_domains_dflt);
    localparam int c_sel_w = w_of(c_num_ports_dflt);

    typedef logic [c_dom_w-1:0] dom_t;

endpackage

// File: rtl/plab4_net_epoch_ctr.sv
// Free-running epoch counter; the owning domain depends only on elapsed cycles.
module plab4_net_epoch_ctr
    import plab4_net_pkg::*;
#(
    parameter int  p_epoch_len   = 8,
    parameter int  p_num_domains = 2,
    localparam int c_dom_w       = w_of(p_num_domains)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [c_dom_w-1:0] cur_dom_o,
    output logic               wrap_o
);

    localparam int c_cnt_w = w_of(p_epoch_len);

    logic [c_cnt_w-1:0] ep_cnt_q, ep_cnt_d;
    logic [c_dom_w-1:0] cur_dom_q, cur_dom_d;

    assign wrap_o    = (ep_cnt_q == c_cnt_w'(p_epoch_len - 1));
    assign cur_dom_o = cur_dom_q;

    always_comb begin
        ep_cnt_d  = ep_cnt_q + 1'b1;
        cur_dom_d = cur_dom_q;
        if (wrap_o) begin
            ep_cnt_d = '0;
            if (cur_dom_q == c_dom_w'(p_num_domains - 1))
                cur_dom_d = '0;
            else
                cur_dom_d = cur_dom_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ep_cnt_q  <= '0;
            cur_dom_q <= '0;
        end else begin
            ep_cnt_q  <= ep_cnt_d;
            cur_dom_q <= cur_dom_d;
        end
    end

endmodule

// File: rtl/plab4_net_router_out_ctrl_tdm.sv
// Output-port controller: TDM epochs across domains, per-domain round-robin
// with packet locks that survive epoch boundaries.
module plab4_net_router_out_ctrl_tdm
    import plab4_net_pkg::*;
#(
    parameter int  p_num_ports   = 3,
    parameter int  p_num_domains = 2,
    parameter int  p_epoch_len   = 8,
    localparam int c_dom_w       = w_of(p_num_domains),
    localparam int c_sel_w       = w_of(p_num_ports)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [p_num_ports-1:0]       reqs,
    input  logic [p_num_ports*c_dom_w-1:0] reqs_domain,
    input  logic [p_num_ports-1:0]       reqs_tail,
    output logic [p_num_ports-1:0]       grants,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic [c_dom_w-1:0]           out_domain,
    output logic [c_sel_w-1:0]           xbar_sel
);

    logic [c_dom_w-1:0]     cur_dom;
    logic                   wrap_unused;
    logic [p_num_ports-1:0] elig;
    logic                   hit;
    logic                   gnt;
    logic [c_sel_w-1:0]     sel;
    logic [c_sel_w-1:0]     rr_d;

    logic               lock_v_q    [p_num_domains];
    logic [c_sel_w-1:0] lock_port_q [p_num_domains];
    logic [c_sel_w-1:0] rr_ptr_q    [p_num_domains];

    plab4_net_epoch_ctr #(
        .p_epoch_len   (p_epoch_len),
        .p_num_domains (p_num_domains)
    ) u_epoch (
        .clk       (clk),
        .reset     (reset),
        .cur_dom_o (cur_dom),
        .wrap_o    (wrap_unused)
    );

    assign out_domain = cur_dom;

    always_comb begin
        elig = '0;
        for (int i = 0; i < p_num_ports; i++)
            elig[i] = reqs[i] && out_rdy &&
                      (reqs_domain[i*c_dom_w +: c_dom_w] == cur_dom);
    end

    // A held lock blocks every other port, even when the locked port is idle.
    always_comb begin : arb
        int idx;
        hit = 1'b0;
        sel = '0;
        idx = 0;
        if (lock_v_q[cur_dom]) begin
            hit = elig[lock_port_q[cur_dom]];
            sel = lock_port_q[cur_dom];
        end else begin
            for (int j = 0; j < p_num_ports; j++) begin
                idx = int'(rr_ptr_q[cur_dom]) + j;
                if (idx >= p_num_ports)
                    idx = idx - p_num_ports;
                if (!hit && elig[idx]) begin
                    hit = 1'b1;
                    sel = c_sel_w'(idx);
                end
            end
        end
    end

    assign gnt      = hit && !reset;
    assign grants   = gnt ? ({{(p_num_ports-1){1'b0}}, 1'b1} << sel) : '0;
    assign out_val  = |grants;
    assign xbar_sel = gnt ? sel : '0;

    assign rr_d = (sel == c_sel_w'(p_num_ports - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < p_num_domains; d++) begin
                lock_v_q[d]    <= 1'b0;
                lock_port_q[d] <= '0;
                rr_ptr_q[d]    <= '0;
            end
        end else if (gnt) begin
            if (reqs_tail[sel]) begin
                lock_v_q[cur_dom] <= 1'b0;
                rr_ptr_q[cur_dom] <= rr_d;
            end else begin
                lock_v_q[cur_dom]    <= 1'b1;
                lock_port_q[cur_dom] <= sel;
            end
        end
    end

endmodule

// File: tb/tb_plab4_net_router_out_ctrl_tdm.sv
// Directed bench for the TDM output controller (3 ports, 2 domains, epoch 8).
module tb_plab4_net_router_out_ctrl_tdm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] reqs = '0;
    logic [2:0] reqs_domain = '0;
    logic [2:0] reqs_tail = '0;
    logic       out_rdy = 1'b0;
    logic [2:0] grants;
    logic       out_val;
    logic [0:0] out_domain;
    logic [1:0] xbar_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    int g;
    logic [2:0] eg;
    logic [2:0] r;
    logic [2:0] t;
    logic       rdy;

    always #5 clk = ~clk;

    plab4_net_router_out_ctrl_tdm #(
        .p_num_ports   (3),
        .p_num_domains (2),
        .p_epoch_len   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reqs        (reqs),
        .reqs_domain (reqs_domain),
        .reqs_tail   (reqs_tail),
        .grants      (grants),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .out_domain  (out_domain),
        .xbar_sel    (xbar_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] rq, input logic [2:0] dm,
                         input logic [2:0] tl, input logic rd);
        reqs        = rq;
        reqs_domain = dm;
        reqs_tail   = tl;
        out_rdy     = rd;
    endtask

    // Check one cycle against expected grants, then advance to the next negedge.
    task automatic step(input string tag, input int k, input logic [2:0] exp_g);
        logic [1:0] es;
        string      s;
        es = exp_g[2] ? 2'd2 : (exp_g[1] ? 2'd1 : 2'd0);
        s  = $sformatf("%s[%0d]", tag, k);
        #1;
        chk({s, ".grants"}, 32'(grants), 32'(exp_g));
        chk({s, ".val"}, 32'(out_val), 32'(|exp_g));
        chk({s, ".sel"}, 32'(xbar_sel), 32'(es));
        chk({s, ".dom"}, 32'(out_domain), 32'((cyc_n / 8) % 2));
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
    endtask

    // Assert reset with live requests, verify the outputs are gated, release.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        drive(3'b111, 3'b000, 3'b000, 1'b1);
        #1;
        chk({tag, ".rst_grants"}, 32'(grants), 32'd0);
        chk({tag, ".rst_val"}, 32'(out_val), 32'd0);
        chk({tag, ".rst_sel"}, 32'(xbar_sel), 32'd0);
        chk({tag, ".rst_dom"}, 32'(out_domain), 32'd0);
        @(negedge clk);
        drive(3'b000, 3'b000, 3'b000, 1'b1);
        reset = 1'b0;
        cyc_n = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset("init");

        for (int k = 0; k < 24; k++)
            step("idle", k, 3'b000);

        do_reset("rr");
        g = 0;
        for (int k = 0; k < 24; k++) begin
            drive(3'b111, 3'b000, 3'b111, 1'b1);
            eg = ((cyc_n / 8) % 2 == 0) ? (3'b001 << (g % 3)) : 3'b000;
            if (eg != 3'b000) g++;
            step("rr", k, eg);
        end

        do_reset("filt");
        for (int k = 0; k < 9; k++) begin
            drive(3'b010, 3'b010, 3'b010, 1'b1);
            step("filt", k, (k == 8) ? 3'b010 : 3'b000);
        end

        do_reset("lock");
        for (int k = 0; k < 24; k++) begin
            r = {(k < 8) || (k >= 16 && k < 20), 1'b0, k >= 1};
            t = {k == 19, 1'b0, 1'b1};
            drive(r, 3'b000, t, 1'b1);
            if (k < 8 || (k >= 16 && k < 20))
                eg = 3'b100;
            else if (k >= 20)
                eg = 3'b001;
            else
                eg = 3'b000;
            step("lock", k, eg);
        end

        do_reset("bp");
        g = 0;
        for (int k = 0; k < 18; k++) begin
            rdy = (k % 2 == 0);
            drive(3'b111, 3'b000, 3'b111, rdy);
            eg = (((cyc_n / 8) % 2 == 0) && rdy) ? (3'b001 << (g % 3)) : 3'b000;
            if (eg != 3'b000) g++;
            step("bp", k, eg);
        end

        do_reset("lasttail");
        for (int k = 0; k < 17; k++) begin
            r = {1'b0, k < 8, k >= 1};
            t = {1'b0, k == 7, 1'b1};
            drive(r, 3'b000, t, 1'b1);
            if (k < 8)
                eg = 3'b010;
            else if (k == 16)
                eg = 3'b001;
            else
                eg = 3'b000;
            step("lasttail", k, eg);
        end

        do_reset("midrst");
        drive(3'b010, 3'b000, 3'b010, 1'b1);
        step("midrst", 0, 3'b010);
        drive(3'b100, 3'b000, 3'b000, 1'b1);
        step("midrst", 1, 3'b100);
        do_reset("midrst2");
        drive(3'b111, 3'b000, 3'b111, 1'b1);
        step("midrst", 2, 3'b001);
        drive(3'b111, 3'b000, 3'b111, 1'b1);
        step("midrst", 3, 3'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
